// File: rtl/calc_key_conditioner.sv
// rtl/calc_key_conditioner.sv - pushbutton sync/debounce and one-hot command pulse arbiter.
// Optional digit auto-repeat is built only when CALC_KEY_AUTO_REPEAT_EN is defined.
module calc_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SW_W            = 6,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      key_n,
    input  logic [SW_W-1:0] sw,
    output logic            digit_pulse,
    output logic            op_pulse,
    output logic            exec_pulse,
    output logic [SW_W-1:0] sw_snap,
    output logic            key_busy
);

    typedef enum logic [1:0] {UP, DEB_DOWN, DOWN, DEB_UP} key_state_e;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 4 || REPEAT_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_param
        $error("calc_key_conditioner: illegal parameter combination");
    end

    logic [2:0]      key_s1_q, key_s2_q;
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;
    key_state_e      state_q [3];
    key_state_e      state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]      press;
    logic [2:0]      pend_q, pend_d;
    logic [2:0]      grant;
    logic [2:0]      pulse_q;
    logic [SW_W-1:0] snap_q, snap_d;
    logic            busy_q, busy_d;
    logic            rpt_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1_q <= 3'b111;
            key_s2_q <= 3'b111;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= UP;
                cnt_q[k]   <= '0;
            end
        end else begin
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                UP: if (!key_s2_q[k]) begin
                    state_d[k] = DEB_DOWN;
                    cnt_d[k]   = CNT_W'(1);
                end
                DEB_DOWN: if (key_s2_q[k]) begin
                    state_d[k] = UP;
                    cnt_d[k]   = '0;
                end else if (cnt_q[k] == DEB_MAX) begin
                    state_d[k] = DOWN;
                    cnt_d[k]   = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
                DOWN: if (key_s2_q[k]) begin
                    state_d[k] = DEB_UP;
                    cnt_d[k]   = CNT_W'(1);
                end
                DEB_UP: if (!key_s2_q[k]) begin
                    state_d[k] = DOWN;
                    cnt_d[k]   = '0;
                end else if (cnt_q[k] == DEB_MAX) begin
                    state_d[k] = UP;
                    cnt_d[k]   = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
                default: begin
                    state_d[k] = UP;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = 1'b0;
        press  = '0;
        for (int k = 0; k < 3; k++) begin
            press[k] = (state_q[k] == DEB_DOWN) && !key_s2_q[k] && (cnt_q[k] == DEB_MAX);
            busy_d   = busy_d | (state_q[k] != UP);
        end
        press[0] = press[0] | rpt_evt;
    end

`ifdef CALC_KEY_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             digit_held;

    // Counts only while the digit key stays down; leaving DOWN restarts the interval.
    assign digit_held = (state_q[0] == DOWN) && !key_s2_q[0];

    always_comb begin
        rpt_d   = '0;
        rpt_evt = 1'b0;
        if (digit_held) begin
            if (rpt_q == RPT_MAX) begin
                rpt_evt = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`else
    assign rpt_evt = 1'b0;
`endif

    // Fixed priority: execute, then op, then digit; losers stay pending.
    always_comb begin
        grant = 3'b000;
        if      (pend_q[2]) grant = 3'b100;
        else if (pend_q[1]) grant = 3'b010;
        else if (pend_q[0]) grant = 3'b001;
        pend_d = (pend_q & ~grant) | press;
        snap_d = grant[0] ? sw_s2_q : snap_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= '0;
            pulse_q <= '0;
            snap_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            pulse_q <= grant;
            snap_q  <= snap_d;
            busy_q  <= busy_d;
        end
    end

    assign digit_pulse = pulse_q[0];
    assign op_pulse    = pulse_q[1];
    assign exec_pulse  = pulse_q[2];
    assign sw_snap     = snap_q;
    assign key_busy    = busy_q;

endmodule
